// File: rtl/fetch_unit.sv
// CHIP-8 instruction fetch: owns the PC, reads one opcode per request and hands it over valid/ready.
// Optional breakpoint/halt support is compiled in when FETCH_BREAKPOINT_EN is defined.
module fetch_unit #(
  parameter int unsigned ADDR_W   = 12,
  parameter logic [15:0] PC_RESET = 16'h0100,
  parameter int unsigned MEM_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              o_mem_r_en,
  output logic [ADDR_W-1:0] o_mem_r_addr,
  input  logic [15:0]       i_mem_r_data,
  input  logic              i_mem_busy,
  output logic [15:0]       o_opcode,
  output logic              o_op_valid,
  input  logic              i_op_ready,
  output logic [15:0]       o_pc_data,
  input  logic [15:0]       i_pc_data,
  input  logic              i_pc_en
`ifdef FETCH_BREAKPOINT_EN
  ,
  input  logic              i_bp_en,
  input  logic [15:0]       i_bp_addr,
  input  logic              i_resume,
  output logic              o_halted
`endif
);

`ifdef FETCH_BREAKPOINT_EN
  typedef enum logic [1:0] {StReq, StWait, StValid, StHalt} state_e;
`else
  typedef enum logic [1:0] {StReq, StWait, StValid} state_e;
`endif

  state_e      state_q;
  logic [15:0] pc_q;
  logic [2:0]  cnt_q;
  logic [15:0] opcode_q;
  logic        op_valid_q;
  logic        bp_hit;

`ifdef FETCH_BREAKPOINT_EN
  logic halted_q;
  logic bp_skip_q;

  // After a resume the first fetch of the halted PC must not re-trigger the breakpoint.
  assign bp_hit   = i_bp_en && (pc_q == i_bp_addr) && !bp_skip_q;
  assign o_halted = halted_q;
`else
  assign bp_hit = 1'b0;
`endif

  // The strobe depends on busy/redirect in the same cycle so a request never collides with them.
  assign o_mem_r_en   = !rst && (state_q == StReq) && !i_mem_busy && !i_pc_en && !bp_hit;
  assign o_mem_r_addr = pc_q[ADDR_W-1:0];
  assign o_opcode     = opcode_q;
  assign o_op_valid   = op_valid_q;
  assign o_pc_data    = pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StReq;
      pc_q       <= PC_RESET;
      cnt_q      <= '0;
      opcode_q   <= '0;
      op_valid_q <= 1'b0;
`ifdef FETCH_BREAKPOINT_EN
      halted_q   <= 1'b0;
      bp_skip_q  <= 1'b0;
`endif
    end else if (i_pc_en) begin
      // Redirect discards anything in flight; an accepted opcode is still consumed.
      pc_q       <= i_pc_data;
      op_valid_q <= 1'b0;
      cnt_q      <= '0;
`ifdef FETCH_BREAKPOINT_EN
      bp_skip_q  <= 1'b0;
      state_q    <= (state_q == StHalt) ? StHalt : StReq;
`else
      state_q    <= StReq;
`endif
    end else begin
      unique case (state_q)
        StReq: begin
          if (bp_hit) begin
`ifdef FETCH_BREAKPOINT_EN
            state_q  <= StHalt;
            halted_q <= 1'b1;
`endif
          end else if (!i_mem_busy) begin
            cnt_q   <= 3'(MEM_LAT - 1);
            state_q <= StWait;
`ifdef FETCH_BREAKPOINT_EN
            bp_skip_q <= 1'b0;
`endif
          end
        end
        StWait: begin
          if (cnt_q == 3'd0) begin
            opcode_q   <= i_mem_r_data;
            op_valid_q <= 1'b1;
            state_q    <= StValid;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        StValid: begin
          if (i_op_ready) begin
            pc_q       <= pc_q + 16'd1;
            op_valid_q <= 1'b0;
            state_q    <= StReq;
          end
        end
`ifdef FETCH_BREAKPOINT_EN
        StHalt: begin
          if (i_resume) begin
            halted_q  <= 1'b0;
            bp_skip_q <= 1'b1;
            state_q   <= StReq;
          end
        end
`endif
        default: state_q <= StReq;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a MEM_LAT=1 instance checked by an opcode scoreboard plus a MEM_LAT=3
// instance sharing the same stimulus for latency checks.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        busy = 1'b0;
  logic        ready = 1'b0;
  logic        pc_en = 1'b0;
  logic [15:0] pc_data = 16'h0000;

  logic        m1_en, m3_en, o1_valid, o3_valid;
  logic [11:0] m1_addr, m3_addr;
  logic [15:0] m1_rdata, m3_rdata, o1_opcode, o3_opcode, o1_pc, o3_pc;

`ifdef FETCH_BREAKPOINT_EN
  logic        bp_en = 1'b0;
  logic        resume = 1'b0;
  logic [15:0] bp_addr = 16'h0000;
  logic        halt1, halt3;
`endif

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [0:4095];

  fetch_unit #(.ADDR_W(12), .PC_RESET(16'h0100), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .o_mem_r_en(m1_en), .o_mem_r_addr(m1_addr), .i_mem_r_data(m1_rdata), .i_mem_busy(busy),
    .o_opcode(o1_opcode), .o_op_valid(o1_valid), .i_op_ready(ready),
    .o_pc_data(o1_pc), .i_pc_data(pc_data), .i_pc_en(pc_en)
`ifdef FETCH_BREAKPOINT_EN
    , .i_bp_en(bp_en), .i_bp_addr(bp_addr), .i_resume(resume), .o_halted(halt1)
`endif
  );

  fetch_unit #(.ADDR_W(12), .PC_RESET(16'h0100), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .o_mem_r_en(m3_en), .o_mem_r_addr(m3_addr), .i_mem_r_data(m3_rdata), .i_mem_busy(busy),
    .o_opcode(o3_opcode), .o_op_valid(o3_valid), .i_op_ready(ready),
    .o_pc_data(o3_pc), .i_pc_data(pc_data), .i_pc_en(pc_en)
`ifdef FETCH_BREAKPOINT_EN
    , .i_bp_en(bp_en), .i_bp_addr(bp_addr), .i_resume(resume), .o_halted(halt3)
`endif
  );

  // Memory models: data is only meaningful exactly MEM_LAT cycles after a strobe.
  logic [15:0] d1_q = 16'h0;
  logic        v1_q = 1'b0;
  logic [15:0] d3_q [3];
  logic [2:0]  v3_q = 3'b000;

  always @(posedge clk) begin
    v1_q     <= m1_en;
    d1_q     <= mem[m1_addr];
    v3_q     <= {v3_q[1:0], m3_en};
    d3_q[0]  <= mem[m3_addr];
    d3_q[1]  <= d3_q[0];
    d3_q[2]  <= d3_q[1];
  end
  assign m1_rdata = v1_q ? d1_q : 16'hDEAD;
  assign m3_rdata = v3_q[2] ? d3_q[2] : 16'hDEAD;

  // Scoreboard for dut1: push on strobe, pop on accept, flush on redirect or reset.
  logic [15:0] sb_q [$];
  logic [15:0] sb_exp;
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (o1_valid && ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_order: opcode %h accepted, expected none outstanding", o1_opcode);
        end else begin
          sb_exp = sb_q.pop_front();
          if (o1_opcode !== sb_exp) begin
            errors++;
            $display("FAIL sb_opcode: got %h expected %h", o1_opcode, sb_exp);
          end
        end
      end
      if (pc_en) sb_q.delete();
      if (m1_en) sb_q.push_back(mem[m1_addr]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    pc_en = 1'b0;
    busy  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (o1_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_valid: got %b expected 1", o1_valid);
    end
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if ({m1_en, o1_valid, o1_opcode, o1_pc} !== {1'b0, 1'b0, 16'h0000, 16'h0100}) begin
      errors++;
      $display("FAIL reset_state: en=%b valid=%b op=%h pc=%h expected 0 0 0000 0100",
               m1_en, o1_valid, o1_opcode, o1_pc);
    end
    checks++;
    if ({m3_en, o3_valid, o3_opcode, o3_pc} !== {1'b0, 1'b0, 16'h0000, 16'h0100}) begin
      errors++;
      $display("FAIL reset_state3: en=%b valid=%b op=%h pc=%h expected 0 0 0000 0100",
               m3_en, o3_valid, o3_opcode, o3_pc);
    end
  endtask

  task automatic test_basic();
    do_reset();
    ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({m1_en, m1_addr} !== {1'b1, 12'h100}) begin
      errors++;
      $display("FAIL basic_strobe: en=%b addr=%h expected 1 100", m1_en, m1_addr);
    end
    tick();
    @(negedge clk);
    checks++;
    if (o1_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_wait_valid: got %b expected 0", o1_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({o1_valid, o1_opcode} !== {1'b1, 16'h6A05}) begin
      errors++;
      $display("FAIL basic_opcode: valid=%b op=%h expected 1 6a05", o1_valid, o1_opcode);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({o1_pc, m1_en, m1_addr} !== {16'h0101, 1'b1, 12'h101}) begin
      errors++;
      $display("FAIL basic_next: pc=%h en=%b addr=%h expected 0101 1 101", o1_pc, m1_en, m1_addr);
    end
  endtask

  task automatic test_stall();
    do_reset();
    ready = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({o1_valid, m1_en, o1_pc, o1_opcode} !== {1'b1, 1'b0, 16'h0100, 16'h6A05}) begin
        errors++;
        $display("FAIL stall_hold: valid=%b en=%b pc=%h op=%h expected 1 0 0100 6a05",
                 o1_valid, m1_en, o1_pc, o1_opcode);
      end
      tick();
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({m1_en, m1_addr} !== {1'b1, 12'h101}) begin
      errors++;
      $display("FAIL stall_next: en=%b addr=%h expected 1 101", m1_en, m1_addr);
    end
    ready = 1'b1;
  endtask

  task automatic test_redirect_wait();
    bit seen;
    do_reset();
    ready = 1'b1;
    tick();
    pc_en   = 1'b1;
    pc_data = 16'h0300;
    @(negedge clk);
    checks++;
    if ({m1_en, o1_valid} !== 2'b00) begin
      errors++;
      $display("FAIL redir_cycle: en=%b valid=%b expected 0 0", m1_en, o1_valid);
    end
    tick();
    pc_en = 1'b0;
    @(negedge clk);
    checks++;
    if ({m1_en, m1_addr, o1_valid} !== {1'b1, 12'h300, 1'b0}) begin
      errors++;
      $display("FAIL redir_strobe: en=%b addr=%h valid=%b expected 1 300 0",
               m1_en, m1_addr, o1_valid);
    end
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      tick();
      @(negedge clk);
      if (o1_valid) seen = 1'b1;
    end
    checks++;
    if (!seen || o1_opcode !== mem[12'h300]) begin
      errors++;
      $display("FAIL redir_opcode: seen=%b op=%h expected 1 %h", seen, o1_opcode, mem[12'h300]);
    end
  endtask

  task automatic test_accept_redirect();
    do_reset();
    ready = 1'b1;
    tick();
    tick();
    pc_en   = 1'b1;
    pc_data = 16'h0123;
    @(negedge clk);
    checks++;
    if (o1_valid !== 1'b1) begin
      errors++;
      $display("FAIL accredir_valid: got %b expected 1", o1_valid);
    end
    tick();
    pc_en = 1'b0;
    @(negedge clk);
    checks++;
    if ({o1_pc, m1_en, m1_addr} !== {16'h0123, 1'b1, 12'h123}) begin
      errors++;
      $display("FAIL accredir_pc: pc=%h en=%b addr=%h expected 0123 1 123", o1_pc, m1_en, m1_addr);
    end
  endtask

  task automatic test_busy_latency();
    int k;
    do_reset();
    ready = 1'b1;
    busy  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({m1_en, m3_en} !== 2'b00) begin
        errors++;
        $display("FAIL busy_strobe: en1=%b en3=%b expected 0 0", m1_en, m3_en);
      end
      tick();
    end
    busy = 1'b0;
    @(negedge clk);
    checks++;
    if ({m3_en, m3_addr, m1_en} !== {1'b1, 12'h100, 1'b1}) begin
      errors++;
      $display("FAIL busy_release: en3=%b addr3=%h en1=%b expected 1 100 1", m3_en, m3_addr, m1_en);
    end
    k = 0;
    for (int n = 1; n <= 8 && k == 0; n++) begin
      tick();
      @(negedge clk);
      if (o3_valid) k = n;
    end
    checks++;
    if (k != 4 || o3_opcode !== 16'h6A05) begin
      errors++;
      $display("FAIL lat3_valid: cycles=%0d op=%h expected 4 6a05", k, o3_opcode);
    end
  endtask

  task automatic test_wrap();
    bit seen;
    do_reset();
    ready   = 1'b1;
    pc_en   = 1'b1;
    pc_data = 16'hFFFF;
    tick();
    pc_en = 1'b0;
    @(negedge clk);
    checks++;
    if ({m1_en, m1_addr} !== {1'b1, 12'hFFF}) begin
      errors++;
      $display("FAIL wrap_trunc: en=%b addr=%h expected 1 fff", m1_en, m1_addr);
    end
    seen = 1'b0;
    for (int n = 0; n < 6 && !seen; n++) begin
      tick();
      @(negedge clk);
      if (o1_valid) seen = 1'b1;
    end
    tick();
    @(negedge clk);
    checks++;
    if (!seen || {o1_pc, m1_addr} !== {16'h0000, 12'h000}) begin
      errors++;
      $display("FAIL wrap_pc: seen=%b pc=%h addr=%h expected 1 0000 000", seen, o1_pc, m1_addr);
    end
  endtask

  task automatic test_back_to_back();
    int cnt;
    do_reset();
    ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (o1_valid) cnt++;
      tick();
    end
    checks++;
    if (cnt != 4) begin
      errors++;
      $display("FAIL b2b_rate: accepts=%0d expected 4", cnt);
    end
  endtask

`ifdef FETCH_BREAKPOINT_EN
  task automatic test_breakpoint();
    bit seen;
    do_reset();
    ready   = 1'b1;
    bp_en   = 1'b1;
    bp_addr = 16'h0102;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick();
      @(negedge clk);
      if (halt1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL bp_halt: halted=%b expected 1", halt1);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({m1_en, o1_valid, o1_pc, halt1} !== {1'b0, 1'b0, 16'h0102, 1'b1}) begin
        errors++;
        $display("FAIL bp_hold: en=%b valid=%b pc=%h halted=%b expected 0 0 0102 1",
                 m1_en, o1_valid, o1_pc, halt1);
      end
      tick();
      @(negedge clk);
    end
    tick();
    resume = 1'b1;
    tick();
    resume = 1'b0;
    @(negedge clk);
    checks++;
    if ({m1_en, m1_addr, halt1} !== {1'b1, 12'h102, 1'b0}) begin
      errors++;
      $display("FAIL bp_resume: en=%b addr=%h halted=%b expected 1 102 0", m1_en, m1_addr, halt1);
    end
    bp_en = 1'b0;
  endtask
`endif

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'(i * 257) ^ 16'hA5C3;
    mem[12'h100] = 16'h6A05;
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_accept_redirect();
    test_busy_latency();
    test_wrap();
    test_back_to_back();
`ifdef FETCH_BREAKPOINT_EN
    test_breakpoint();
`endif
    rst = 1'b1;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
